// File: rtl/tmds_word_aligner.sv
// TMDS word aligner: finds the 10-bit word boundary of each raw TMDS channel by
// hunting for control tokens, sliding a bit offset until tokens appear, and holding
// lock while tokens keep arriving. Each channel is aligned independently.
module tmds_word_aligner #(
    parameter int unsigned          CHANNELS   = 3,
    parameter int unsigned          LOCK_COUNT = 8,
    parameter int unsigned          TIMEOUT    = 1024,
    parameter logic [CHANNELS-1:0]  INVERT     = {CHANNELS{1'b0}}
) (
    input  logic                    hdmi_clk,
    input  logic                    reset,
    input  logic [CHANNELS*10-1:0]  in,
    output logic [CHANNELS*10-1:0]  out,
    output logic [CHANNELS-1:0]     ctrl_strobe,
    output logic [CHANNELS-1:0]     locked,
    output logic                    all_locked,
    output logic [CHANNELS*4-1:0]   slip
);

    localparam int unsigned      IdleW   = $clog2(TIMEOUT);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT - 1);
    localparam logic [7:0]       LockCnt = 8'(LOCK_COUNT);

    typedef enum logic [1:0] {
        StSearch,
        StVerify,
        StLocked
    } state_e;

    // Only the four DVI/HDMI control-period codes count; TERC4 is deliberately ignored.
    function automatic logic is_ctrl_token(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    logic all_locked_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [9:0]       cur_word;
        logic [9:0]       prev_q;
        logic [19:0]      window;
        logic [9:0]       aligned;
        logic             token;
        logic             idle_expired;
        logic [3:0]       slip_next;
        logic [9:0]       out_q;
        logic             strobe_q;
        state_e           state_q, state_d;
        logic [IdleW-1:0] idle_q, idle_d;
        logic [7:0]       tok_cnt_q, tok_cnt_d;
        logic [3:0]       slip_q, slip_d;

        assign cur_word     = in[c*10 +: 10] ^ {10{INVERT[c]}};
        // Earlier word sits in the low half, so slip 0 selects prev unchanged.
        assign window       = {cur_word, prev_q};
        assign aligned      = 10'(window >> slip_q);
        assign token        = is_ctrl_token(aligned);
        assign idle_expired = (idle_q == IdleMax);
        assign slip_next    = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;

        // Word history and registered aligned output.
        always_ff @(posedge hdmi_clk or posedge reset) begin
            if (reset) begin
                prev_q   <= '0;
                out_q    <= '0;
                strobe_q <= 1'b0;
            end else begin
                prev_q   <= cur_word;
                out_q    <= aligned;
                strobe_q <= token;
            end
        end

        // Alignment FSM state, counters and bit offset.
        always_ff @(posedge hdmi_clk or posedge reset) begin
            if (reset) begin
                state_q   <= StSearch;
                idle_q    <= '0;
                tok_cnt_q <= '0;
                slip_q    <= '0;
            end else begin
                state_q   <= state_d;
                idle_q    <= idle_d;
                tok_cnt_q <= tok_cnt_d;
                slip_q    <= slip_d;
            end
        end

        // Next-state logic; a token always beats a coincident timeout.
        always_comb begin
            state_d   = state_q;
            idle_d    = idle_q + IdleW'(1);
            tok_cnt_d = tok_cnt_q;
            slip_d    = slip_q;
            if (token) begin
                idle_d = '0;
                unique case (state_q)
                    StSearch: begin
                        tok_cnt_d = 8'd1;
                        state_d   = (LockCnt == 8'd1) ? StLocked : StVerify;
                    end
                    StVerify: begin
                        if (tok_cnt_q + 8'd1 >= LockCnt) begin
                            tok_cnt_d = LockCnt;
                            state_d   = StLocked;
                        end else begin
                            tok_cnt_d = tok_cnt_q + 8'd1;
                        end
                    end
                    StLocked: begin
                        tok_cnt_d = LockCnt;
                    end
                    default: begin
                        state_d   = StSearch;
                        tok_cnt_d = '0;
                    end
                endcase
            end else if (idle_expired) begin
                idle_d = '0;
                unique case (state_q)
                    StSearch: begin
                        slip_d = slip_next;
                    end
                    StVerify: begin
                        state_d   = StSearch;
                        slip_d    = slip_next;
                        tok_cnt_d = '0;
                    end
                    StLocked: begin
                        // A paused source keeps its offset; only search again from here.
                        state_d   = StSearch;
                        tok_cnt_d = '0;
                    end
                    default: begin
                        state_d   = StSearch;
                        tok_cnt_d = '0;
                    end
                endcase
            end
        end

        assign out[c*10 +: 10] = out_q;
        assign ctrl_strobe[c]  = strobe_q;
        assign locked[c]       = (state_q == StLocked);
        assign slip[c*4 +: 4]  = slip_q;
    end

    // Registered AND of per-channel lock.
    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset) begin
            all_locked_q <= 1'b0;
        end else begin
            all_locked_q <= &locked;
        end
    end

    assign all_locked = all_locked_q;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner: two instances (short and default timeout)
// driven from one linear stimulus sequence with hand-computed expectations.
module tb_tmds_word_aligner;

    logic        hdmi_clk = 1'b0;
    logic        reset;
    logic [29:0] in_a, out_a, in_b, out_b;
    logic [2:0]  strobe_a, locked_a, strobe_b, locked_b;
    logic        all_a, all_b;
    logic [11:0] slip_a, slip_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 hdmi_clk = ~hdmi_clk;

    tmds_word_aligner #(
        .CHANNELS   (3),
        .LOCK_COUNT (8),
        .TIMEOUT    (16),
        .INVERT     (3'b010)
    ) u_dut_a (
        .hdmi_clk    (hdmi_clk),
        .reset       (reset),
        .in          (in_a),
        .out         (out_a),
        .ctrl_strobe (strobe_a),
        .locked      (locked_a),
        .all_locked  (all_a),
        .slip        (slip_a)
    );

    tmds_word_aligner #(
        .CHANNELS   (3),
        .LOCK_COUNT (8),
        .TIMEOUT    (1024),
        .INVERT     (3'b000)
    ) u_dut_b (
        .hdmi_clk    (hdmi_clk),
        .reset       (reset),
        .in          (in_b),
        .out         (out_b),
        .ctrl_strobe (strobe_b),
        .locked      (locked_b),
        .all_locked  (all_b),
        .slip        (slip_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Raw word seen when a repeating symbol stream is delayed by d bits.
    function automatic logic [9:0] rot(input logic [9:0] sym, input int d);
        logic [19:0] t;
        t = {sym, sym};
        return 10'(t >> (10 - d));
    endfunction

    task automatic step();
        @(posedge hdmi_clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        @(posedge hdmi_clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge hdmi_clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Channel 0 of instance A carries 354 on words first..last, zero elsewhere.
    task automatic drive_a0_to(input int n, input int first, input int last);
        while (cyc < n) begin
            in_a = {20'h0, ((cyc >= first) && (cyc <= last)) ? 10'h354 : 10'h000};
            step();
        end
    endtask

    // Instance B channel 0: tokens, 2000 words of pixel data, tokens again.
    task automatic drive_b_to(input int n);
        while (cyc < n) begin
            in_b = {20'h0, ((cyc < 20) || (cyc >= 2020)) ? 10'h354
                                                         : (10'h0F0 + 10'(cyc % 7))};
            step();
        end
    endtask

    initial begin
        reset = 1'b0;
        in_a  = '0;
        in_b  = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_out", out_a, 0);
        check("rst_locked", {locked_a, all_a}, 0);
        check("rst_slip", slip_a, 0);

        // Three channels at offsets 0, 5 (inverted), 9 with continuous tokens.
        do_reset();
        in_a = {rot(10'h354, 9), ~rot(10'h354, 5), rot(10'h354, 0)};
        run_to(2);
        check("ch0_out_354", out_a[9:0], 10'h354);
        check("ch0_strobe", strobe_a[0], 1);
        run_to(8);
        check("ch0_not_yet_locked", locked_a, 3'b000);
        run_to(9);
        check("ch0_locked", locked_a, 3'b001);
        run_to(15);
        check("slip_before_timeout", slip_a, 12'h000);
        run_to(16);
        check("slip_first_step", slip_a, 12'h110);
        run_to(80);
        check("slip_at_80", slip_a, 12'h550);
        run_to(81);
        check("ch1_out_354", out_a[19:10], 10'h354);
        check("ch1_strobe", strobe_a[1], 1);
        run_to(87);
        check("ch1_not_yet_locked", locked_a, 3'b001);
        run_to(88);
        check("ch1_locked", locked_a, 3'b011);
        run_to(152);
        check("ch2_locked", locked_a, 3'b111);
        check("all_locked_lags", all_a, 0);
        run_to(153);
        check("all_locked", all_a, 1);
        check("slip_059", slip_a, 12'h950);
        check("ch2_out_354", out_a[29:20], 10'h354);
        run_to(200);
        check("slip_held", slip_a, 12'h950);

        // Asynchronous reset mid-cycle while locked.
        #3 reset = 1'b1;
        #1;
        check("async_out", out_a, 0);
        check("async_strobe", strobe_a, 0);
        check("async_locked", {locked_a, all_a}, 0);
        check("async_slip", slip_a, 0);
        @(posedge hdmi_clk);
        #1;
        reset = 1'b0;
        cyc   = 0;

        // Channel 0 delayed by 3 bits: slip walks 0..3, then lock.
        in_a = {20'h0, rot(10'h354, 3)};
        #1;
        check("restart_slip0", slip_a[3:0], 0);
        run_to(15);
        check("d3_slip_0", slip_a[3:0], 0);
        run_to(16);
        check("d3_slip_1", slip_a[3:0], 1);
        run_to(32);
        check("d3_slip_2", slip_a[3:0], 2);
        run_to(48);
        check("d3_slip_3", slip_a[3:0], 3);
        check("d3_no_strobe", strobe_a[0], 0);
        run_to(49);
        check("d3_strobe", strobe_a[0], 1);
        check("d3_out", out_a[9:0], 10'h354);
        run_to(55);
        check("d3_not_locked", locked_a[0], 0);
        run_to(56);
        check("d3_locked", locked_a[0], 1);
        run_to(159);
        check("ch2_slip_9", slip_a[11:8], 9);
        run_to(160);
        check("ch2_slip_wrap", slip_a[11:8], 0);
        check("d3_slip_kept", slip_a[3:0], 3);

        // Token arriving exactly at idle == TIMEOUT-1 in SEARCH.
        do_reset();
        drive_a0_to(16, 14, 100000);
        check("edge_no_slip", slip_a[3:0], 0);
        check("edge_strobe", strobe_a[0], 1);
        check("edge_not_locked", locked_a[0], 0);
        drive_a0_to(22, 14, 100000);
        check("edge_pre_lock", locked_a[0], 0);
        drive_a0_to(23, 14, 100000);
        check("edge_locked", locked_a[0], 1);
        check("edge_slip_kept", slip_a[3:0], 0);

        // Tokens stop in VERIFY: timeout slips.
        do_reset();
        drive_a0_to(19, 0, 2);
        check("verify_to_slip0", slip_a[3:0], 0);
        drive_a0_to(20, 0, 2);
        check("verify_to_slip1", slip_a[3:0], 1);
        check("verify_to_unlocked", locked_a[0], 0);

        // Default timeout: lock, 2000 pixel words, drop, relock at same slip.
        do_reset();
        drive_b_to(9);
        check("b_locked", locked_b[0], 1);
        drive_b_to(1044);
        check("b_still_locked", locked_b[0], 1);
        drive_b_to(1045);
        check("b_dropped", locked_b[0], 0);
        check("b_slip_kept", slip_b[3:0], 0);
        drive_b_to(2028);
        check("b_pre_relock", locked_b[0], 0);
        drive_b_to(2029);
        check("b_relocked", locked_b[0], 1);
        check("b_relock_slip", slip_b[3:0], 0);
        check("b_out", out_b[9:0], 10'h354);
        check("b_all_low", all_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
